// File: rtl/cpu_pkg.sv
// Shared register-file types: address/data widths and the buffered mul/div result entry.
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    reg_addr_t addr;
    data_t     data;
  } md_entry_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of the WB, mul/div, decode-hazard and RegFile write-port signals around the arbiter.
interface rf_write_arbiter_if;
  import cpu_pkg::*;

  logic                wb_we;
  reg_addr_t           wb_addr;
  data_t               wb_data;
  logic                md_valid;
  logic                md_ready;
  reg_addr_t           md_addr;
  data_t               md_data;
  logic                md_issue;
  reg_addr_t           md_issue_addr;
  reg_addr_t           rs_addr;
  reg_addr_t           rt_addr;
  logic                stall;
  logic                wb_hold;
  logic [NUM_REGS-1:0] busy_vec;
  logic                rf_we;
  reg_addr_t           rf_waddr;
  data_t               rf_wdata;

  modport master (
    output wb_we, wb_addr, wb_data, md_valid, md_addr, md_data,
           md_issue, md_issue_addr, rs_addr, rt_addr,
    input  md_ready, stall, wb_hold, busy_vec, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, md_valid, md_addr, md_data,
           md_issue, md_issue_addr, rs_addr, rt_addr,
    output md_ready, stall, wb_hold, busy_vec, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/rf_result_fifo.sv
// Small power-of-two FIFO holding mul/div results until the write port is free.
module rf_result_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  md_entry_t              push_entry,
  input  logic                   pop,
  output md_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  md_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: storage carries no reset; an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has priority, mul/div results drain from a FIFO,
// a starvation counter forces a drain, and a busy scoreboard raises decode stalls.
module rf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  rf_write_arbiter_if.slave bus
);
  localparam int                  SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [NUM_REGS-1:0] R0_MASK    = NUM_REGS'(1);

  md_entry_t                head;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     grant_md;
  logic                     grant_wb;
  logic                     push;
  logic [SW-1:0]            starve_cnt;
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      set_mask;
  logic [NUM_REGS-1:0]      clr_mask;
  logic                     rf_we_q;
  reg_addr_t                rf_waddr_q;
  data_t                    rf_wdata_q;

  assign bus.wb_hold  = (starve_cnt == STARVE_MAX);
  assign bus.md_ready = (fifo_count < ($clog2(DEPTH)+1)'(DEPTH));
  assign bus.busy_vec = busy;
  assign bus.stall    = busy[bus.rs_addr] | busy[bus.rt_addr];
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // A held pipeline cedes the port to the FIFO head; a WB request under hold is dropped.
  assign grant_md = !fifo_empty && (bus.wb_hold || !bus.wb_we);
  assign grant_wb = bus.wb_we && !bus.wb_hold && !grant_md;
  assign push     = bus.md_valid && (!fifo_full || grant_md);

  rf_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{addr: bus.md_addr, data: bus.md_data}),
    .pop        (grant_md),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || grant_md) begin
      starve_cnt <= '0;
    end else if (grant_wb && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.md_issue) set_mask[bus.md_issue_addr] = 1'b1;
    if (grant_md)     clr_mask[head.addr]         = 1'b1;
  end

  // Set is applied after clear so a same-cycle reissue keeps the register busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= ((busy & ~clr_mask) | set_mask) & ~R0_MASK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (grant_md) begin
      rf_we_q    <= (head.addr != '0);
      rf_waddr_q <= head.addr;
      rf_wdata_q <= head.data;
    end else if (grant_wb) begin
      rf_we_q    <= (bus.wb_addr != '0);
      rf_waddr_q <= bus.wb_addr;
      rf_wdata_q <= bus.wb_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end
endmodule
